adder_share_arbiter: RTL and testbench

//   Time-multiplexes one adder instance between NUM_REQ requesters with round-robin arbitration.

---
 rtl/adder_share_pkg.sv | 10 +
 rtl/adder_share_arbiter_if.sv | 27 ++
 rtl/adder_share_arbiter_adder.sv | 26 ++
 rtl/adder_share_arbiter.sv | 98 +++++++++
 tb/tb_adder_share_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the round-robin adder-sharing arbiter.
package adder_share_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OPERATE,
      RESPOND
   } arb_state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester/consumer bundle for adder_share_arbiter; master is the traffic side, slave the block.
interface adder_share_arbiter_if #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 16,
   parameter int unsigned OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
   parameter int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*A_WIDTH-1:0] req_a;
   logic [NUM_REQ*B_WIDTH-1:0] req_b;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [OUT_WIDTH-1:0]       rsp_sum;
   logic [ID_WIDTH-1:0]        rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id
   );
endinterface

// File: rtl/adder_share_arbiter_adder.sv
// The single shared adder: sign-extends both operands, adds, applies an arithmetic right shift.
module adder_share_arbiter_adder #(
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 16,
   parameter int unsigned OUT_SCALE = 0,
   parameter int unsigned OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1
) (
   input  logic signed [A_WIDTH-1:0]   a,
   input  logic signed [B_WIDTH-1:0]   b,
   output logic signed [OUT_WIDTH-1:0] sum
);
   localparam int unsigned MaxW = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
   // Internal width never loses the carry and is at least as wide as the result.
   localparam int unsigned SumW = (MaxW + 1 > OUT_WIDTH) ? MaxW + 1 : OUT_WIDTH;

   logic signed [SumW-1:0] a_ext;
   logic signed [SumW-1:0] b_ext;
   logic signed [SumW-1:0] full;
   logic signed [SumW-1:0] shifted;

   assign a_ext   = {{(SumW - A_WIDTH){a[A_WIDTH-1]}}, a};
   assign b_ext   = {{(SumW - B_WIDTH){b[B_WIDTH-1]}}, b};
   assign full    = a_ext + b_ext;
   assign shifted = full >>> OUT_SCALE;
   assign sum     = shifted[OUT_WIDTH-1:0];
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one registered adder between NUM_REQ requesters.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 16,
   parameter int unsigned OUT_SCALE = 0,
   parameter int unsigned OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
   parameter int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic                 clk,
   input logic                 arst_n_in,
   adder_share_arbiter_if.slave bus
);
   arb_state_t                  state_q, state_d;
   logic [ID_WIDTH-1:0]         last_grant_q;
   logic [ID_WIDTH-1:0]         grant;
   logic                        grant_found;
   logic                        accept;
   logic [ID_WIDTH-1:0]         op_id_q;
   logic signed [A_WIDTH-1:0]   op_a_q;
   logic signed [B_WIDTH-1:0]   op_b_q;
   logic signed [OUT_WIDTH-1:0] sum;
   logic signed [OUT_WIDTH-1:0] res_q;
   int unsigned                 idx;

   // Cyclic search starting just after the previous winner.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      idx         = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant_q) + off) % NUM_REQ;
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = ID_WIDTH'(idx);
         end
      end
   end

   assign accept = (state_q == IDLE) && grant_found;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = OPERATE;
         OPERATE: state_d = RESPOND;
         RESPOND: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q      <= IDLE;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
         op_id_q      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         res_q        <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= grant;
            op_id_q      <= grant;
            op_a_q       <= bus.req_a[int'(grant) * A_WIDTH +: A_WIDTH];
            op_b_q       <= bus.req_b[int'(grant) * B_WIDTH +: B_WIDTH];
         end
         if (state_q == OPERATE) begin
            res_q <= sum;
         end
      end
   end

   // Adder sees only the operand registers, so it has a full cycle to settle.
   adder_share_arbiter_adder #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .OUT_SCALE(OUT_SCALE),
      .OUT_WIDTH(OUT_WIDTH)
   ) u_adder (
      .a  (op_a_q),
      .b  (op_b_q),
      .sum(sum)
   );

   assign bus.rsp_valid = (state_q == RESPOND);
   assign bus.rsp_sum   = res_q;
   assign bus.rsp_id    = op_id_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: two instances (scale 0 and 1) on identical traffic vs. a model.
module tb_adder_share_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]      req_valid;
   logic               rsp_ready;
   logic signed [15:0] op_a [NR];
   logic signed [15:0] op_b [NR];
   logic [NR*16-1:0]   flat_a, flat_b;

   always_comb begin
      flat_a = '0;
      flat_b = '0;
      for (int i = 0; i < NR; i++) begin
         flat_a[i*16 +: 16] = op_a[i];
         flat_b[i*16 +: 16] = op_b[i];
      end
   end

   adder_share_arbiter_if bus0 ();
   adder_share_arbiter_if bus1 ();

   assign bus0.req_valid = req_valid;
   assign bus0.req_a     = flat_a;
   assign bus0.req_b     = flat_b;
   assign bus0.rsp_ready = rsp_ready;
   assign bus1.req_valid = req_valid;
   assign bus1.req_a     = flat_a;
   assign bus1.req_b     = flat_b;
   assign bus1.rsp_ready = rsp_ready;

   adder_share_arbiter #(.OUT_SCALE(0)) dut0 (.clk(clk), .arst_n_in(arst_n), .bus(bus0));
   adder_share_arbiter #(.OUT_SCALE(1)) dut1 (.clk(clk), .arst_n_in(arst_n), .bus(bus1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Hand-computed expectations injected by the stimulus for specific cycles.
   bit          lit_rdy_en = 0;
   logic [NR-1:0] lit_rdy = '0;
   bit          lit_rsp_en = 0;
   int          lit_s0 = 0, lit_s1 = 0, lit_id = 0;

   // Model: one transaction in flight, response two cycles after acceptance.
   bit          m_busy = 0;
   int          m_wait = 0;
   int          m_last = NR - 1;
   int          m_id = 0, m_a = 0, m_b = 0;
   logic [NR-1:0] exp_rdy;
   int          g;
   bit          found, exp_v;

   always @(negedge clk) begin
      if (!arst_n) begin
         chk("rst_rsp_valid0", longint'(bus0.rsp_valid), 0);
         chk("rst_rsp_valid1", longint'(bus1.rsp_valid), 0);
         m_busy = 0;
         m_last = NR - 1;
      end else begin
         exp_rdy = '0;
         found   = 0;
         g       = 0;
         if (!m_busy) begin
            for (int off = 1; off <= NR; off++) begin
               if (!found && req_valid[(m_last + off) % NR]) begin
                  found = 1;
                  g     = (m_last + off) % NR;
               end
            end
            if (found) exp_rdy[g] = 1'b1;
         end
         exp_v = m_busy && (m_wait == 0);
         chk("req_ready0", longint'(bus0.req_ready), longint'(exp_rdy));
         chk("req_ready1", longint'(bus1.req_ready), longint'(exp_rdy));
         chk("rsp_valid0", longint'(bus0.rsp_valid), longint'(exp_v));
         chk("rsp_valid1", longint'(bus1.rsp_valid), longint'(exp_v));
         if (exp_v) begin
            chk("rsp_sum0", longint'($signed(bus0.rsp_sum)), longint'(m_a + m_b));
            chk("rsp_sum1", longint'($signed(bus1.rsp_sum)), longint'((m_a + m_b) >>> 1));
            chk("rsp_id0", longint'(bus0.rsp_id), longint'(m_id));
            chk("rsp_id1", longint'(bus1.rsp_id), longint'(m_id));
         end
         if (lit_rdy_en) chk("lit_ready", longint'(bus0.req_ready), longint'(lit_rdy));
         if (lit_rsp_en) begin
            chk("lit_valid", longint'(bus0.rsp_valid), 1);
            chk("lit_sum0", longint'($signed(bus0.rsp_sum)), longint'(lit_s0));
            chk("lit_sum1", longint'($signed(bus1.rsp_sum)), longint'(lit_s1));
            chk("lit_id", longint'(bus0.rsp_id), longint'(lit_id));
         end
         if (!m_busy) begin
            if (found) begin
               m_busy = 1;
               m_wait = 1;
               m_id   = g;
               m_a    = int'(op_a[g]);
               m_b    = int'(op_b[g]);
               m_last = g;
            end
         end else if (m_wait > 0) begin
            m_wait--;
         end else if (rsp_ready) begin
            m_busy = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lit_rsp(input int s0, input int s1, input int id);
      lit_rsp_en = 1;
      lit_s0     = s0;
      lit_s1     = s1;
      lit_id     = id;
   endtask

   task automatic pulse_reset();
      arst_n = 1'b0;
      step();
      step();
      arst_n = 1'b1;
   endtask

   int s0_tab [NR] = '{999, 1998, 2997, 3996};
   int s1_tab [NR] = '{499, 999, 1498, 1998};

   initial begin
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 arst_n = 1'b1;

      // Single request straight out of reset.
      op_a[0] = 16'sd100;
      op_b[0] = -16'sd30;
      req_valid = 4'b0001;
      lit_rdy_en = 1; lit_rdy = 4'b0001;
      step();
      lit_rdy_en = 0; req_valid = '0;
      step();
      set_lit_rsp(70, 35, 0);
      step();
      lit_rsp_en = 0;

      // All requesting, fresh pointer: order 0,1,2,3,0.
      pulse_reset();
      for (int i = 0; i < NR; i++) begin
         op_a[i] = 16'(1000 * (i + 1));
         op_b[i] = 16'(-(i + 1));
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 15; k++) begin
         if (k % 3 == 2) set_lit_rsp(s0_tab[(k / 3) % NR], s1_tab[(k / 3) % NR], (k / 3) % NR);
         step();
         lit_rsp_en = 0;
      end
      req_valid = '0;
      step();

      // Consumer stall: response held, nothing granted, then pointer advances.
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      lit_rdy_en = 1; lit_rdy = 4'b0010;
      step();
      lit_rdy = 4'b0000;
      step();
      for (int k = 0; k < 10; k++) begin
         set_lit_rsp(1998, 999, 1);
         step();
      end
      rsp_ready = 1'b1;
      step();
      lit_rsp_en = 0;
      lit_rdy = 4'b0100;
      step();
      lit_rdy_en = 0; req_valid = '0;
      repeat (3) step();

      // Extremes.
      op_a[3] = 16'sd32767; op_b[3] = 16'sd32767;
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      step();
      set_lit_rsp(65534, 32767, 3);
      step();
      lit_rsp_en = 0;
      op_a[0] = -16'sd32768; op_b[0] = -16'sd32768;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      set_lit_rsp(-65536, -32768, 0);
      step();
      lit_rsp_en = 0;

      // Reset while OPERATE: transaction dropped, requester 0 wins afterwards.
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      pulse_reset();
      req_valid = 4'b1111;
      lit_rdy_en = 1; lit_rdy = 4'b0001;
      step();
      lit_rdy_en = 0; req_valid = '0;
      repeat (3) step();

      // Random traffic.
      for (int k = 0; k < 10000; k++) begin
         req_valid = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               op_a[i] = 16'($urandom);
               op_b[i] = 16'($urandom);
            end
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
